// File: rtl/gth_frame_pkg.sv
// Frame layout, counter widths and receiver FSM states.
// Shared by the GTH sample-frame packer (TX) and the frame receiver (RX).
package gth_frame_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int WORD_W  = 80;
  localparam int HDR_LSB = 72;
  localparam int HDR_W   = 8;
  localparam int SEQ_LSB = 64;
  localparam int SEQ_W   = 8;
  localparam int CH_NUM  = 4;
  localparam int CH_W    = 16;
  localparam int POP_W   = 5;
  localparam int CNT_W   = 20;
  localparam int WIN_W   = 16;
  localparam int RUN_W   = 16;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } frame_state_e;

  // Channel c occupies payload bits [16c+15:16c].
  function automatic logic [CH_W-1:0] chSlice(input logic [WORD_W-1:0] word, input int c);
    return word[c*CH_W +: CH_W];
  endfunction

endpackage

// File: rtl/gth_sample_frame_rx_popcnt16.sv
// Combinational ones-count of a 16-bit channel slice.
module popcnt16 (
  input  logic [15:0] data_i,
  output logic [4:0]  count_o
);

  logic [1:0] pair [8];
  logic [2:0] quad [4];
  logic [3:0] oct  [2];

  // Balanced adder tree keeps the path short at GTH usrclk2 rates.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pair[i] = {1'b0, data_i[2*i]} + {1'b0, data_i[2*i+1]};
    end
    for (int i = 0; i < 4; i++) begin
      quad[i] = {1'b0, pair[2*i]} + {1'b0, pair[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      oct[i] = {1'b0, quad[2*i]} + {1'b0, quad[2*i+1]};
    end
    count_o = {1'b0, oct[0]} + {1'b0, oct[1]};
  end

endmodule

// File: rtl/gth_sample_frame_rx.sv
// GTH sample-frame receiver: header lock FSM plus per-channel ones-count
// accumulation over a programmable window, with a valid/ready result port.
module gth_sample_frame_rx
  import gth_frame_pkg::*;
#(
  parameter int         LOCK_GOOD = 4,
  parameter int         LOCK_BAD  = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic          rx_clk,
  input  logic          reset,
  input  logic [79:0]   rx_data,
  input  logic          rx_data_en,
  input  logic [15:0]   window_len,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [79:0]   res_cnt,
  output logic          locked,
  output logic [15:0]   seq_err_cnt,
  output logic          overflow
);

  localparam logic [RUN_W-1:0] LOCK_GOOD_C = RUN_W'(LOCK_GOOD);
  localparam logic [RUN_W-1:0] LOCK_BAD_C  = RUN_W'(LOCK_BAD);

  frame_state_e     state_q;
  logic [SEQ_W-1:0] seq_q;
  logic [RUN_W-1:0] goodRun_q;
  logic [RUN_W-1:0] badRun_q;
  logic [WIN_W-1:0] winCnt_q;
  logic [WIN_W-1:0] winLen_q;
  logic [CNT_W-1:0] acc_q [CH_NUM];
  logic             resValid_q;
  logic [79:0]      resCnt_q;
  logic             locked_q;
  logic [15:0]      seqErr_q;
  logic             overflow_q;

  logic [POP_W-1:0] pop [CH_NUM];
  logic [CNT_W-1:0] accSum_d [CH_NUM];
  logic [79:0]      resCnt_d;
  logic [SEQ_W-1:0] rxSeq;
  logic             syncOk;
  logic             goodHdr;
  logic [WIN_W-1:0] winLenEff;
  logic [WIN_W-1:0] curLen;
  logic             lastWord;
  logic             lockLost;
  logic             loadOk;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_pop
    popcnt16 u_popcnt (
      .data_i  (chSlice(rx_data, c)),
      .count_o (pop[c])
    );
  end

  // Header qualification and window bookkeeping for the word on rx_data.
  // The window length is latched on the first word, so curLen uses the
  // live input only when the word counter is at zero.
  always_comb begin
    rxSeq     = rx_data[SEQ_LSB +: SEQ_W];
    syncOk    = (rx_data[HDR_LSB +: HDR_W] == SYNC_BYTE);
    goodHdr   = syncOk && (rxSeq == seq_q + 8'd1);
    winLenEff = (window_len == '0) ? WIN_W'(1) : window_len;
    curLen    = (winCnt_q == '0) ? winLenEff : winLen_q;
    lastWord  = ((winCnt_q + WIN_W'(1)) == curLen);
    lockLost  = !goodHdr && ((badRun_q + RUN_W'(1)) >= LOCK_BAD_C);
    loadOk    = !resValid_q || res_ready;
    resCnt_d  = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      accSum_d[c] = acc_q[c] + (goodHdr ? {{(CNT_W-POP_W){1'b0}}, pop[c]} : '0);
      resCnt_d[c*CNT_W +: CNT_W] = accSum_d[c];
    end
  end

  // Lock FSM, accumulation and result handshake. A load on the same edge as
  // a completed transfer overrides the valid clear, giving back-to-back results.
  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      seq_q      <= '0;
      goodRun_q  <= '0;
      badRun_q   <= '0;
      winCnt_q   <= '0;
      winLen_q   <= '0;
      resValid_q <= 1'b0;
      resCnt_q   <= '0;
      locked_q   <= 1'b0;
      seqErr_q   <= '0;
      overflow_q <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      if (resValid_q && res_ready) begin
        resValid_q <= 1'b0;
      end
      if (rx_data_en) begin
        case (state_q)
          ST_HUNT: begin
            if (syncOk) begin
              seq_q     <= rxSeq;
              goodRun_q <= RUN_W'(1);
              if (LOCK_GOOD_C <= RUN_W'(1)) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
                badRun_q <= '0;
                winCnt_q <= '0;
                for (int c = 0; c < CH_NUM; c++) begin
                  acc_q[c] <= '0;
                end
              end else begin
                state_q <= ST_VERIFY;
              end
            end
          end
          ST_VERIFY: begin
            if (goodHdr) begin
              seq_q     <= rxSeq;
              goodRun_q <= goodRun_q + RUN_W'(1);
              if ((goodRun_q + RUN_W'(1)) >= LOCK_GOOD_C) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
                badRun_q <= '0;
                winCnt_q <= '0;
                for (int c = 0; c < CH_NUM; c++) begin
                  acc_q[c] <= '0;
                end
              end
            end else begin
              state_q   <= ST_HUNT;
              goodRun_q <= '0;
            end
          end
          ST_LOCKED: begin
            seq_q <= rxSeq;
            if (goodHdr) begin
              badRun_q <= '0;
            end else begin
              badRun_q <= badRun_q + RUN_W'(1);
              if (seqErr_q != 16'hFFFF) begin
                seqErr_q <= seqErr_q + 16'd1;
              end
            end
            if (lockLost) begin
              state_q   <= ST_HUNT;
              locked_q  <= 1'b0;
              goodRun_q <= '0;
              badRun_q  <= '0;
              winCnt_q  <= '0;
              for (int c = 0; c < CH_NUM; c++) begin
                acc_q[c] <= '0;
              end
            end else if (lastWord) begin
              winCnt_q <= '0;
              for (int c = 0; c < CH_NUM; c++) begin
                acc_q[c] <= '0;
              end
              if (loadOk) begin
                resCnt_q   <= resCnt_d;
                resValid_q <= 1'b1;
              end else begin
                overflow_q <= 1'b1;
              end
            end else begin
              winCnt_q <= winCnt_q + WIN_W'(1);
              if (winCnt_q == '0) begin
                winLen_q <= curLen;
              end
              for (int c = 0; c < CH_NUM; c++) begin
                acc_q[c] <= accSum_d[c];
              end
            end
          end
          default: begin
            state_q  <= ST_HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign res_valid   = resValid_q;
  assign res_cnt     = resCnt_q;
  assign locked      = locked_q;
  assign seq_err_cnt = seqErr_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_gth_sample_frame_rx.sv
// Directed bench for gth_sample_frame_rx: expected results are queued when
// a window's last word is driven and compared when the DUT hands them over.
module tb_gth_sample_frame_rx;

  logic        rx_clk = 1'b0;
  logic        reset = 1'b1;
  logic [79:0] rx_data = '0;
  logic        rx_data_en = 1'b0;
  logic [15:0] window_len = 16'd2;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [79:0] res_cnt;
  logic        locked;
  logic [15:0] seq_err_cnt;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [79:0] sb [$];
  logic [19:0] acc [4];
  logic [79:0] heldResult;

  gth_sample_frame_rx dut (
    .rx_clk      (rx_clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_data_en  (rx_data_en),
    .window_len  (window_len),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_cnt     (res_cnt),
    .locked      (locked),
    .seq_err_cnt (seq_err_cnt),
    .overflow    (overflow)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One word per call; inputs change 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic [7:0] sync, input logic [7:0] seq, input logic [63:0] pay);
    rx_data    = {sync, seq, pay};
    rx_data_en = 1'b1;
    @(posedge rx_clk);
    #1;
    rx_data_en = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rx_clk);
      #1;
    end
  endtask

  task automatic modelClear();
    for (int c = 0; c < 4; c++) acc[c] = '0;
  endtask

  task automatic modelAdd(input logic [63:0] pay);
    for (int c = 0; c < 4; c++) acc[c] = acc[c] + 20'($countones(pay[16*c +: 16]));
  endtask

  function automatic logic [79:0] modelPack();
    return {acc[3], acc[2], acc[1], acc[0]};
  endfunction

  // Each handshake consumes exactly one queued expectation.
  always @(negedge rx_clk) begin
    if (!reset && res_valid && res_ready) begin
      logic [79:0] exp;
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checkOutput("res_cnt_xfer", res_cnt, exp);
    end
  end

  initial begin
    logic [63:0] pay;
    logic [7:0]  s8;

    idleCycles(2);
    checkOutput("rst_locked", 80'(locked), 80'd0);
    checkOutput("rst_valid", 80'(res_valid), 80'd0);
    checkOutput("rst_overflow", 80'(overflow), 80'd0);
    checkOutput("rst_res_cnt", res_cnt, 80'd0);
    checkOutput("rst_seq_err", 80'(seq_err_cnt), 80'd0);
    reset = 1'b0;
    idleCycles(1);

    // Bad sync in VERIFY drops back to HUNT; then a clean 4-word lock.
    applyStimulus(8'hA5, 8'd0, 64'd0);
    applyStimulus(8'hA5, 8'd1, 64'd0);
    applyStimulus(8'h5A, 8'd2, 64'd0);
    checkOutput("verify_bad_unlocked", 80'(locked), 80'd0);
    applyStimulus(8'hA5, 8'd10, 64'd0);
    applyStimulus(8'hA5, 8'd11, 64'd0);
    applyStimulus(8'hA5, 8'd12, 64'd0);
    checkOutput("three_good_unlocked", 80'(locked), 80'd0);
    applyStimulus(8'hA5, 8'd13, 64'd0);
    checkOutput("lock_after_four", 80'(locked), 80'd1);

    // Window of two: 16 + 4 ones per channel.
    res_ready = 1'b1;
    applyStimulus(8'hA5, 8'd14, 64'hFFFF_FFFF_FFFF_FFFF);
    sb.push_back({4{20'd20}});
    applyStimulus(8'hA5, 8'd15, 64'h000F_000F_000F_000F);
    checkOutput("count_valid", 80'(res_valid), 80'd1);

    // Random payloads across the 255 -> 0 sequence wrap.
    modelClear();
    for (int s = 16; s < 258; s++) begin
      pay = {$urandom, $urandom};
      s8 = 8'(s);
      modelAdd(pay);
      if (((s - 16) % 2) == 1) begin
        sb.push_back(modelPack());
        modelClear();
      end
      applyStimulus(8'hA5, s8, pay);
    end
    idleCycles(2);
    checkOutput("wrap_seq_err", 80'(seq_err_cnt), 80'd0);
    checkOutput("wrap_still_locked", 80'(locked), 80'd1);

    // Four bad syncs inside an 8-word window: lock lost, window discarded.
    window_len = 16'd8;
    applyStimulus(8'hA5, 8'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(8'h00, 8'd3, 64'd0);
    applyStimulus(8'h00, 8'd4, 64'd0);
    applyStimulus(8'h00, 8'd5, 64'd0);
    checkOutput("three_bad_locked", 80'(locked), 80'd1);
    applyStimulus(8'h00, 8'd6, 64'd0);
    checkOutput("lol_unlocked", 80'(locked), 80'd0);
    checkOutput("lol_seq_err", 80'(seq_err_cnt), 80'd4);
    idleCycles(3);
    checkOutput("lol_no_result", 80'(res_valid), 80'd0);

    // Relock, then three one-word windows with the sink stalled.
    applyStimulus(8'hA5, 8'd20, 64'd0);
    applyStimulus(8'hA5, 8'd21, 64'd0);
    applyStimulus(8'hA5, 8'd22, 64'd0);
    applyStimulus(8'hA5, 8'd23, 64'd0);
    checkOutput("relock", 80'(locked), 80'd1);
    res_ready  = 1'b0;
    window_len = 16'd1;
    pay = 64'h0123_4567_89AB_CDEF;
    modelClear();
    modelAdd(pay);
    heldResult = modelPack();
    sb.push_back(heldResult);
    applyStimulus(8'hA5, 8'd24, pay);
    checkOutput("bp_valid", 80'(res_valid), 80'd1);
    checkOutput("bp_no_ovf_yet", 80'(overflow), 80'd0);
    applyStimulus(8'hA5, 8'd25, 64'hFFFF_0000_FFFF_0000);
    checkOutput("bp_hold_1", res_cnt, heldResult);
    checkOutput("bp_overflow", 80'(overflow), 80'd1);
    applyStimulus(8'hA5, 8'd26, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("bp_hold_2", res_cnt, heldResult);
    res_ready = 1'b1;
    idleCycles(3);
    checkOutput("bp_released", 80'(res_valid), 80'd0);
    checkOutput("bp_sb_drained", 80'(sb.size()), 80'd0);

    // Asynchronous reset in the middle of a four-word window.
    window_len = 16'd4;
    applyStimulus(8'hA5, 8'd27, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(8'hA5, 8'd28, 64'hFFFF_FFFF_FFFF_FFFF);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_locked", 80'(locked), 80'd0);
    checkOutput("arst_overflow", 80'(overflow), 80'd0);
    checkOutput("arst_seq_err", 80'(seq_err_cnt), 80'd0);
    checkOutput("arst_res_cnt", res_cnt, 80'd0);
    checkOutput("arst_valid", 80'(res_valid), 80'd0);
    @(posedge rx_clk);
    #1;
    reset = 1'b0;
    window_len = 16'd1;
    applyStimulus(8'hA5, 8'd40, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(8'hA5, 8'd41, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(8'hA5, 8'd42, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("post_rst_unlocked", 80'(locked), 80'd0);
    checkOutput("post_rst_no_result", 80'(res_valid), 80'd0);
    applyStimulus(8'hA5, 8'd43, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("post_rst_relock", 80'(locked), 80'd1);

    // Zero window length behaves as one word per window.
    window_len = 16'd0;
    pay = 64'h8000_0001_00FF_F00F;
    modelClear();
    modelAdd(pay);
    sb.push_back(modelPack());
    applyStimulus(8'hA5, 8'd44, pay);
    checkOutput("zero_len_valid", 80'(res_valid), 80'd1);
    idleCycles(3);
    checkOutput("final_sb_empty", 80'(sb.size()), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gth_sample_frame_rx.md
GTH_SAMPLE_FRAME_RX -- requirements
Module: gth_sample_frame_rx

Interface
REQ-001 Parameter LOCK_GOOD, default 4: consecutive good headers needed to enter LOCKED.
REQ-002 Parameter LOCK_BAD, default 4: consecutive bad headers needed to leave LOCKED.
REQ-003 Parameter SYNC_BYTE, default 8'hA5: frame sync pattern.
REQ-004 rx_clk  in  1  GTH RX usrclk2; the only clock.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 rx_data  in  80  GTH user RX word, valid every cycle.
REQ-007 rx_data_en  in  1  qualifies rx_data; ignore words while low.
REQ-008 window_len  in  16  words per accumulation window; sampled at window start.
REQ-009 res_valid  out  1  result handshake valid.
REQ-010 res_ready  in  1  result handshake ready.
REQ-011 res_cnt  out  80  four 20-bit ones-counts, ch0 at [19:0] through ch3 at [79:60].
REQ-012 locked  out  1  high in LOCKED state.
REQ-013 seq_err_cnt  out  16  saturating count of sequence errors while locked.
REQ-014 overflow  out  1  sticky: a completed window was dropped.

Function
REQ-015 Word format: [79:72] = SYNC_BYTE, [71:64] = 8-bit sequence; [63:0] = payload, 16 samples per channel, channel c in bits [16c+15:16c].
REQ-016 Good header: [79:72] == SYNC_BYTE and, except in HUNT, sequence == previous sequence + 1 mod 256 (255 -> 0 is good).
REQ-017 FSM states: HUNT, VERIFY, LOCKED.
REQ-018 HUNT -> VERIFY on first word with correct sync byte; that word's sequence is stored.
REQ-019 In VERIFY, a bad header returns to HUNT; LOCK_GOOD total good headers, counting the HUNT word, -> LOCKED.
REQ-020 In LOCKED, a bad header increments the bad run and seq_err_cnt; the stored sequence resyncs to the received value; any good header clears the bad run.
REQ-021 LOCK_BAD consecutive bad headers -> HUNT; the partial window is discarded.
REQ-022 Accumulation runs only in LOCKED, on good-header words only; bad-header words are not counted but do advance the window word counter.
REQ-023 Per channel, add popcount of its 16 payload bits, 0..16, to a 20-bit accumulator; no saturation needed, since 65535*16 < 2^20.
REQ-024 window_len == 0 is treated as 1.
REQ-025 On the last word of a window: if the output is empty, or res_ready is high that cycle, load res_cnt (final sum including that word) and assert res_valid on the next cycle.
REQ-026 Otherwise, drop the result and set overflow.
REQ-027 Accumulators restart with the next word, zero bubble.
REQ-028 res_valid/res_cnt hold stable until res_valid & res_ready; res_cnt is unchanged while res_valid is high.
REQ-029 Leaving LOCKED does not cancel a pending res_valid.

Reset
REQ-030 Reset applies asynchronously: state HUNT; locked, res_valid, overflow 0; res_cnt, seq_err_cnt, accumulators, counters, stored sequence 0.
REQ-031 Reset deasserts cleanly without glitching outputs; an in-flight result is lost.

Structure
REQ-032 Shared package gth_frame_pkg holds SYNC_BYTE default, field positions/widths (header, sequence, per-channel slices), CH_NUM=4, CNT_W=20, and the FSM state enum.
REQ-033 One sub-module: popcnt16, a combinational 16-bit popcount, instantiated per channel.
REQ-034 Package shared with the transmit-side frame packer.

Verification
REQ-035 Lock: 4 words A5/seq 0..3 -> locked rises on the cycle after the 4th word; one bad-sync word during VERIFY -> back to HUNT.
REQ-036 Counting: window_len=2, payload all-ones then 0x000F per channel -> res_cnt each channel = 20 (16+4).
REQ-037 Wrap: sequence 254,255,0,1 while locked -> seq_err_cnt stays 0.
REQ-038 Loss of lock: 4 consecutive wrong-sync words -> locked falls, seq_err_cnt=4, no result emitted for that window.
REQ-039 Backpressure: window_len=1, res_ready held low for 3 windows -> first result held unchanged, overflow=1.
REQ-040 Backpressure release: res_ready high -> the held result transfers exactly once.
REQ-041 Reset mid-window: assert reset during window -> all outputs 0 immediately, relock required before any result.
